fake_n64_controller_tx: RTL and testbench

FAKE_N64_CONTROLLER_TX -- requirements
Module: fake_n64_controller_tx

---
 rtl/fake_n64_controller_tx.sv | 176 +++++++++++++++++
 tb/tb_fake_n64_controller_tx.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fake_n64_controller_tx.sv
// Fake N64 controller transmit stage.
// Answers a command byte handed over by the receive stage (via a toggle on
// tx_handoff) with either the 24-bit info word or the 32-bit button word,
// using the N64 one-wire cell encoding and a trailing stop bit.
// Optional build macro: FAKE_N64_TX_PAK_EN -- when defined the info word
// reports a controller pak as present (0x050001); otherwise 0x050002.
// Timing: one us prescaler plus a 2-bit us counter drive every phase, so
// TURN_US must lie in 1..4 and US_TICKS in 2..255.

module fake_n64_controller_tx #(
  parameter int US_TICKS = 4,
  parameter int TURN_US  = 2
) (
  input  logic        sample_clk,
  input  logic        reset,
  input  logic        tx_handoff,
  input  logic [7:0]  cmd,
  input  logic [31:0] buttons,
  output logic        data_tx,
  output logic        cur_operation
);

`ifdef FAKE_N64_TX_PAK_EN
  localparam logic [23:0] LP_INFO_WORD = 24'h050001;
`else
  localparam logic [23:0] LP_INFO_WORD = 24'h050002;
`endif

  localparam logic [7:0] LP_PRE_MAX   = 8'(US_TICKS - 1);
  localparam logic [1:0] LP_TURN_LOAD = 2'(TURN_US - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_STOP_LOW,
    S_STOP_HIGH
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_prev;
  logic [7:0]  r_pre;
  logic [1:0]  r_us;
  logic [5:0]  r_bitCnt;
  logic [31:0] r_word;
  logic        r_dataTx;
  logic        r_curOp;

  logic        w_change;
  logic        w_usEnd;
  logic        w_phaseEnd;
  logic [4:0]  w_nextIdx;
  logic        w_curBit;
  logic        w_nextBit;

  assign w_change   = r_sync2 ^ r_prev;
  assign w_usEnd    = (r_pre == LP_PRE_MAX);
  assign w_phaseEnd = w_usEnd && (r_us == 2'd0);
  assign w_nextIdx  = r_bitCnt[4:0] - 5'd1;
  assign w_curBit   = r_word[r_bitCnt[4:0]];
  assign w_nextBit  = r_word[w_nextIdx];

  assign data_tx       = r_dataTx;
  assign cur_operation = r_curOp;

  // Bring the handoff toggle into this clock domain; the third copy always
  // follows, so toggles seen while busy are absorbed rather than queued.
  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= tx_handoff;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Response sequencer: prescaler, us counter, bit counter and the
  // registered line/busy outputs all advance together here.
  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pre    <= 8'd0;
      r_us     <= 2'd0;
      r_bitCnt <= 6'd0;
      r_word   <= 32'd0;
      r_dataTx <= 1'b1;
      r_curOp  <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_pre <= 8'd0;
      end else if (w_usEnd) begin
        r_pre <= 8'd0;
      end else begin
        r_pre <= r_pre + 8'd1;
      end

      if (w_usEnd && (r_us != 2'd0)) begin
        r_us <= r_us - 2'd1;
      end

      case (r_state)
        S_IDLE: begin
          r_dataTx <= 1'b1;
          r_curOp  <= 1'b0;
          if (w_change) begin
            if ((cmd == 8'h00) || (cmd == 8'hFF)) begin
              r_word   <= {8'h00, LP_INFO_WORD};
              r_bitCnt <= 6'd23;
              r_us     <= LP_TURN_LOAD;
              r_curOp  <= 1'b1;
              r_state  <= S_TURN;
            end else if (cmd == 8'h01) begin
              r_word   <= buttons;
              r_bitCnt <= 6'd31;
              r_us     <= LP_TURN_LOAD;
              r_curOp  <= 1'b1;
              r_state  <= S_TURN;
            end
          end
        end
        S_TURN: begin
          if (w_phaseEnd) begin
            r_dataTx <= 1'b0;
            r_us     <= w_curBit ? 2'd0 : 2'd2;
            r_state  <= S_BIT_LOW;
          end
        end
        S_BIT_LOW: begin
          if (w_phaseEnd) begin
            r_dataTx <= 1'b1;
            r_us     <= w_curBit ? 2'd2 : 2'd0;
            r_state  <= S_BIT_HIGH;
          end
        end
        S_BIT_HIGH: begin
          if (w_phaseEnd) begin
            r_dataTx <= 1'b0;
            if (r_bitCnt == 6'd0) begin
              r_us    <= 2'd0;
              r_state <= S_STOP_LOW;
            end else begin
              r_bitCnt <= r_bitCnt - 6'd1;
              r_us     <= w_nextBit ? 2'd0 : 2'd2;
              r_state  <= S_BIT_LOW;
            end
          end
        end
        S_STOP_LOW: begin
          if (w_phaseEnd) begin
            r_dataTx <= 1'b1;
            r_us     <= 2'd1;
            r_state  <= S_STOP_HIGH;
          end
        end
        S_STOP_HIGH: begin
          if (w_phaseEnd) begin
            r_curOp <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_dataTx <= 1'b1;
          r_curOp  <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fake_n64_controller_tx.sv
// Testbench for fake_n64_controller_tx.
// The reference model describes a response as a list of line run lengths
// (turnaround high, then low/high per cell, then stop low/high) and the
// captured waveform is reduced to the same list for comparison.
// Honours FAKE_N64_TX_PAK_EN for the expected info word.

module tb_fake_n64_controller_tx;

  localparam int US_TICKS = 4;
  localparam int TURN_US  = 2;
  localparam int U        = US_TICKS;

`ifdef FAKE_N64_TX_PAK_EN
  localparam logic [23:0] INFO_WORD = 24'h050001;
`else
  localparam logic [23:0] INFO_WORD = 24'h050002;
`endif

  logic        sample_clk;
  logic        reset;
  logic        tx_handoff;
  logic [7:0]  cmd;
  logic [31:0] buttons;
  logic        data_tx;
  logic        cur_operation;

  int total;
  int bad;
  int capLat;
  bit capTimeout;
  int capSegs[$];
  int expSegs[$];

  fake_n64_controller_tx #(
    .US_TICKS(US_TICKS),
    .TURN_US (TURN_US)
  ) dut (
    .sample_clk   (sample_clk),
    .reset        (reset),
    .tx_handoff   (tx_handoff),
    .cmd          (cmd),
    .buttons      (buttons),
    .data_tx      (data_tx),
    .cur_operation(cur_operation)
  );

  // Free-running sample clock, 10 time units per period.
  initial begin
    sample_clk = 1'b0;
    forever #5 sample_clk = ~sample_clk;
  end

  // Expected run lengths of the line while busy, built from the cell rules.
  function automatic void buildExpected(input logic [31:0] word, input int nbits);
    expSegs.delete();
    expSegs.push_back(TURN_US * U);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (word[i]) begin
        expSegs.push_back(U);
        expSegs.push_back(3 * U);
      end else begin
        expSegs.push_back(3 * U);
        expSegs.push_back(U);
      end
    end
    expSegs.push_back(U);
    expSegs.push_back(2 * U);
  endfunction

  task automatic toggleHandoff();
    @(negedge sample_clk);
    tx_handoff = ~tx_handoff;
  endtask

  // Record latency to busy and the run lengths of data_tx while busy.
  task automatic captureResponse(input bit disturb);
    int cnt;
    int run;
    int cyc;
    logic lvl;
    capSegs.delete();
    capTimeout = 1'b0;
    cnt = 0;
    while (cnt < 20) begin
      @(negedge sample_clk);
      cnt++;
      if (cur_operation === 1'b1) break;
    end
    capLat = cnt;
    if (cur_operation !== 1'b1) begin
      capTimeout = 1'b1;
      return;
    end
    run = 1;
    lvl = data_tx;
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge sample_clk);
      cyc++;
      if (disturb && cyc == 200) begin
        tx_handoff = ~tx_handoff;
        buttons    = $urandom;
      end
      if (cur_operation !== 1'b1) break;
      if (data_tx === lvl) begin
        run++;
      end else begin
        capSegs.push_back(run);
        run = 1;
        lvl = data_tx;
      end
    end
    capSegs.push_back(run);
    if (cyc >= 3000) capTimeout = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] cmdV, input logic [31:0] btnV);
    cmd     = cmdV;
    buttons = btnV;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (data_tx !== 1'b1 || cur_operation !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_assert got data_tx=%b cur_op=%b exp 1/0", data_tx, cur_operation);
    end
    repeat (3) @(negedge sample_clk);
    reset = 1'b0;
    repeat (5) @(negedge sample_clk);
    total++;
    if (data_tx !== 1'b1 || cur_operation !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_idle got data_tx=%b cur_op=%b exp 1/0", data_tx, cur_operation);
    end
  endtask

  task automatic test_info(input logic [7:0] cmdV);
    applyStimulus(cmdV, $urandom);
    toggleHandoff();
    captureResponse(1'b0);
    buildExpected({8'h00, INFO_WORD}, 24);
    total++;
    if (capLat !== 3) begin
      bad++;
      $display("[TB] FAIL info_latency cmd=%h got=%0d exp=3", cmdV, capLat);
    end
    total++;
    if (capTimeout || capSegs.size() != expSegs.size()) begin
      bad++;
      $display("[TB] FAIL info_runs cmd=%h got=%0d runs exp=%0d", cmdV, capSegs.size(), expSegs.size());
    end else begin
      foreach (expSegs[i]) begin
        total++;
        if (capSegs[i] != expSegs[i]) begin
          bad++;
          $display("[TB] FAIL info_run%0d cmd=%h got=%0d exp=%0d", i, cmdV, capSegs[i], expSegs[i]);
        end
      end
    end
    total++;
    if (data_tx !== 1'b1) begin
      bad++;
      $display("[TB] FAIL info_release got=%b exp=1", data_tx);
    end
  endtask

  task automatic test_buttons(input logic [31:0] word);
    applyStimulus(8'h01, word);
    toggleHandoff();
    captureResponse(1'b0);
    buildExpected(word, 32);
    total++;
    if (capLat !== 3) begin
      bad++;
      $display("[TB] FAIL btn_latency word=%h got=%0d exp=3", word, capLat);
    end
    total++;
    if (capTimeout || capSegs.size() != expSegs.size()) begin
      bad++;
      $display("[TB] FAIL btn_runs word=%h got=%0d exp=%0d", word, capSegs.size(), expSegs.size());
    end else begin
      foreach (expSegs[i]) begin
        total++;
        if (capSegs[i] != expSegs[i]) begin
          bad++;
          $display("[TB] FAIL btn_run%0d word=%h got=%0d exp=%0d", i, word, capSegs[i], expSegs[i]);
        end
      end
    end
    total++;
    if (data_tx !== 1'b1) begin
      bad++;
      $display("[TB] FAIL btn_release got=%b exp=1", data_tx);
    end
  endtask

  task automatic test_no_response(input logic [7:0] cmdV);
    bit busySeen;
    busySeen = 1'b0;
    applyStimulus(cmdV, $urandom);
    toggleHandoff();
    repeat (300) begin
      @(negedge sample_clk);
      if (data_tx !== 1'b1 || cur_operation !== 1'b0) busySeen = 1'b1;
    end
    total++;
    if (busySeen) begin
      bad++;
      $display("[TB] FAIL no_response cmd=%h got activity exp idle", cmdV);
    end
  endtask

  task automatic test_back_to_back();
    test_buttons($urandom);
    test_buttons($urandom);
  endtask

  task automatic test_disturb();
    logic [31:0] word;
    bit busySeen;
    word = $urandom;
    applyStimulus(8'h01, word);
    toggleHandoff();
    captureResponse(1'b1);
    buildExpected(word, 32);
    total++;
    if (capTimeout || capSegs.size() != expSegs.size()) begin
      bad++;
      $display("[TB] FAIL disturb_runs got=%0d exp=%0d", capSegs.size(), expSegs.size());
    end else begin
      foreach (expSegs[i]) begin
        total++;
        if (capSegs[i] != expSegs[i]) begin
          bad++;
          $display("[TB] FAIL disturb_run%0d got=%0d exp=%0d", i, capSegs[i], expSegs[i]);
        end
      end
    end
    busySeen = 1'b0;
    repeat (60) begin
      @(negedge sample_clk);
      if (data_tx !== 1'b1 || cur_operation !== 1'b0) busySeen = 1'b1;
    end
    total++;
    if (busySeen) begin
      bad++;
      $display("[TB] FAIL disturb_second got activity exp idle");
    end
  endtask

  task automatic test_reset_mid();
    int falls;
    int cyc;
    logic prevLvl;
    bit busySeen;
    applyStimulus(8'h01, $urandom);
    toggleHandoff();
    falls   = 0;
    cyc     = 0;
    prevLvl = 1'b1;
    while (falls < 11 && cyc < 2000) begin
      @(negedge sample_clk);
      cyc++;
      if (prevLvl === 1'b1 && data_tx === 1'b0) falls++;
      prevLvl = data_tx;
    end
    total++;
    if (falls < 11) begin
      bad++;
      $display("[TB] FAIL rstmid_reach got=%0d cells exp=11", falls);
    end
    @(negedge sample_clk);
    #2;
    reset      = 1'b1;
    tx_handoff = 1'b0;
    #1;
    total++;
    if (data_tx !== 1'b1 || cur_operation !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rstmid_release got data_tx=%b cur_op=%b exp 1/0", data_tx, cur_operation);
    end
    repeat (3) @(negedge sample_clk);
    reset = 1'b0;
    busySeen = 1'b0;
    repeat (300) begin
      @(negedge sample_clk);
      if (data_tx !== 1'b1 || cur_operation !== 1'b0) busySeen = 1'b1;
    end
    total++;
    if (busySeen) begin
      bad++;
      $display("[TB] FAIL rstmid_quiet got activity exp idle");
    end
  endtask

  task automatic test_reset_held();
    logic [31:0] word;
    word = $urandom;
    applyStimulus(8'h01, word);
    @(negedge sample_clk);
    reset      = 1'b1;
    tx_handoff = 1'b1;
    repeat (2) @(negedge sample_clk);
    reset = 1'b0;
    captureResponse(1'b0);
    buildExpected(word, 32);
    total++;
    if (capLat !== 3) begin
      bad++;
      $display("[TB] FAIL held_latency got=%0d exp=3", capLat);
    end
    total++;
    if (capTimeout || capSegs.size() != expSegs.size()) begin
      bad++;
      $display("[TB] FAIL held_runs got=%0d exp=%0d", capSegs.size(), expSegs.size());
    end else begin
      foreach (expSegs[i]) begin
        total++;
        if (capSegs[i] != expSegs[i]) begin
          bad++;
          $display("[TB] FAIL held_run%0d got=%0d exp=%0d", i, capSegs[i], expSegs[i]);
        end
      end
    end
  endtask

  // Scenario sequence.
  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    tx_handoff = 1'b0;
    cmd        = 8'h00;
    buttons    = 32'h0;
    test_reset();
    test_info(8'h00);
    test_info(8'hFF);
    test_buttons(32'h80000001);
    repeat (3) test_buttons($urandom);
    test_no_response(8'h02);
    repeat (3) test_no_response(8'($urandom_range(2, 254)));
    test_back_to_back();
    test_disturb();
    test_reset_mid();
    test_reset_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
